seg_mux_n: RTL and testbench
============================

Name: seg_mux_n

Overview:
Parametrised time-multiplexed 7-segment display driver and successor to the fixed 4-digit driver. It scans NUM_DIGITS common-anode digits and decodes BCD or hex per digit. It adds a per-digit decimal point, leading-zero blanking, per-digit blink and a frame-coherent input snapshot. It sits between the timer/counter datapath and the board's seg/an/dp pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8).
REFRESH_COUNT, 100_000, clock cycles per digit slot (multiple of 16, >=16).
BLINK_COUNT, 50_000_000, clock cycles per blink half-period (>=1).
HEX_MODE, 1, 1 = values A-F decode to glyphs; 0 = values 10-15 display blank.

Ports:
clk_100MHz  in  1  system clock.
reset  in  1  synchronous, active-high reset.
digits  in  4*NUM_DIGITS  digit values; bits [3:0] = digit 0 (rightmost), top nibble = leftmost.
dp  in  NUM_DIGITS  decimal-point request per digit, bit i = digit i.
blank_lz  in  1  1 = blank leading zeros.
blink  in  NUM_DIGITS  per-digit blink enable.
seg  out  7 [0:6]  active-low segments; seg[0]=a ... seg[6]=g.
dp_n  out  1  active-low decimal point.
an  out  NUM_DIGITS  active-low anode enables; an[i] = digit i.

Behaviour:
- Clock and reset: single clock clk_100MHz. Reset is synchronous, active-high.
- Reset values:
  - Outputs: an all 1, seg 7'b1111111, dp_n 1.
  - Internal: slot timer 0, index NUM_DIGITS-1, blink timer 0, blink phase 0, snapshot 0.
  - Reset asserted mid-frame takes effect on the next edge and overrides everything.
- Slot timer:
  - Counts 0..REFRESH_COUNT-1, then wraps to 0.
  - On wrap, index decrements; from 0 it wraps to NUM_DIGITS-1.
  - Scan order is leftmost to rightmost, one slot per digit.
- Snapshot:
  - digits, dp, blank_lz and blink are captured into a snapshot register on any cycle with slot timer==0 and index==NUM_DIGITS-1 (frame start).
  - This includes the first cycle after reset release.
  - Input changes mid-frame are not displayed until the next frame start.
- Output register: seg, dp_n and an are registered.
  - They reflect index and snapshot from the previous cycle (1-cycle latency).
  - The first lit digit appears 2 cycles after reset release.
- Decode (active low, abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - HEX_MODE=1: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - HEX_MODE=0: values 10-15 give 1111111.
- Leading-zero blanking:
  - Applies when snapshot blank_lz=1.
  - Digit i (i>0) is blanked (seg=1111111) if it and every digit above it are 0.
  - Digit 0 is never blanked.
  - A blanked digit still drives dp_n = ~dp[i], and an stays asserted.
- dp_n = ~dp[index] for the active digit.
- Blink:
  - Blink timer counts 0..BLINK_COUNT-1; phase toggles on each wrap.
  - While phase=1, any digit with blink[i]=1 gets an all 1, seg 1111111, dp_n 1 for its slot.
  - Blink is independent of scan alignment.
- Priority, highest first: reset > blink-off > brightness-off > blank > decode.
- Exactly one an bit is low at any time, except at reset, during blink-off and during brightness-off.

Optional Feature:
Macro SEG_BRIGHTNESS_EN.
- Defined:
  - Adds port brightness (in, 4 bits), sampled with the snapshot.
  - Within each slot, the active an bit is low only while slot timer < (brightness+1)*(REFRESH_COUNT/16); it is all 1 otherwise.
  - seg is 1111111 and dp_n is 1 whenever an is off.
  - brightness=15 gives a full slot.
  - The threshold is a registered product: no divider, constant shift/multiply only.
- Undefined: port absent; the digit is lit for the full slot.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_COUNT=16, BLINK_COUNT=64 unless noted.
1. Reset scan: digits=16'h1234, dp=0, blank_lz=0 -> an cycles 0111,1011,1101,1110, each held 16 cycles; seg 1001111, 0010010, 0000110, 1001100 respectively; dp_n=1; pattern repeats every 64 cycles.
2. LZ blanking: digits=16'h0070, blank_lz=1 -> digits 3,2 show 1111111; digit 1 shows 0001111; digit 0 shows 0000001. digits=16'h0000 -> only digit 0 shows 0000001. With blank_lz=0, all digits are decoded.
3. Snapshot coherence: change digits 16'h1111->16'h2222 at slot 2 of a frame -> rest of frame shows 1001111; the next frame shows 0010010 on all digits.
4. Hex decode: digits=16'hABCD, HEX_MODE=1 -> 0001000, 1100000, 0110001, 1000010. HEX_MODE=0 -> all 1111111 with an still scanning. dp=4'b0100 -> dp_n=0 only while an=1011.
5. Blink: blink=4'b0001 -> digit 0 slot has an=1111 during cycles where blink phase=1 (timer cycles 64-127 after reset); other digits unaffected.
6. Reset mid-frame: assert reset at slot 2 timer 7 -> next edge an=1111, seg=1111111, dp_n=1; after release, first lit an=0111 at cycle 2. With SEG_BRIGHTNESS_EN and brightness=3, an low for 4 of 16 cycles per slot.

Source files
------------

// File: rtl/seg_mux_n.sv
// seg_mux_n: time-multiplexed common-anode 7-segment driver for NUM_DIGITS digits.
// Each digit gets one slot of REFRESH_COUNT cycles. The scan runs from the leftmost
// digit to the rightmost.
// The block provides BCD/hex decode, a per-digit decimal point, leading-zero blanking
// and per-digit blink.
// The inputs are snapshotted once per frame, so a frame never mixes old and new values.
// Optional build macro SEG_BRIGHTNESS_EN adds a 4-bit brightness port. It sets the
// duty cycle inside each slot.
module seg_mux_n #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_COUNT = 100_000,
    parameter int BLINK_COUNT   = 50_000_000,
    parameter int HEX_MODE      = 1
) (
    input  logic                      clk_100MHz,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic                      blank_lz,
    input  logic [NUM_DIGITS-1:0]     blink,
`ifdef SEG_BRIGHTNESS_EN
    input  logic [3:0]                brightness,
`endif
    output logic [0:6]                seg,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int SLOT_W  = $clog2(REFRESH_COUNT);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int BLINK_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

    localparam logic [SLOT_W-1:0]     SLOT_MAX  = SLOT_W'(REFRESH_COUNT - 1);
    localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0]    BLINK_MAX = BLINK_W'(BLINK_COUNT - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [6:0]            SEG_OFF   = 7'b1111111;

    // Active-low abcdefg glyph for one nibble; a is the MSB of the result
    function automatic logic [6:0] decode_glyph(input logic [3:0] val);
        logic [6:0] glyph;
        case (val)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = (HEX_MODE != 0) ? 7'b0001000 : SEG_OFF;
            4'hB:    glyph = (HEX_MODE != 0) ? 7'b1100000 : SEG_OFF;
            4'hC:    glyph = (HEX_MODE != 0) ? 7'b0110001 : SEG_OFF;
            4'hD:    glyph = (HEX_MODE != 0) ? 7'b1000010 : SEG_OFF;
            4'hE:    glyph = (HEX_MODE != 0) ? 7'b0110000 : SEG_OFF;
            4'hF:    glyph = (HEX_MODE != 0) ? 7'b0111000 : SEG_OFF;
            default: glyph = SEG_OFF;
        endcase
        return glyph;
    endfunction

    logic [SLOT_W-1:0]       slot_r;
    logic [IDX_W-1:0]        idx_r;
    logic [BLINK_W-1:0]      blink_cnt_r;
    logic                    blink_phase_r;
    logic                    lit_en_r;
    logic [4*NUM_DIGITS-1:0] snap_digits_r;
    logic [NUM_DIGITS-1:0]   snap_dp_r;
    logic                    snap_blank_lz_r;
    logic [NUM_DIGITS-1:0]   snap_blink_r;

    logic                    slot_wrap_s;
    logic                    frame_start_s;
    logic [4*NUM_DIGITS-1:0] disp_digits_s;
    logic [NUM_DIGITS-1:0]   disp_dp_s;
    logic                    disp_blank_lz_s;
    logic [NUM_DIGITS-1:0]   disp_blink_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    logic [3:0]              cur_val_s;
    logic                    bright_on_s;
    logic [NUM_DIGITS-1:0]   an_d_s;
    logic [6:0]              seg_d_s;
    logic                    dp_n_d_s;

    assign slot_wrap_s   = (slot_r == SLOT_MAX);
    assign frame_start_s = (slot_r == {SLOT_W{1'b0}}) && (idx_r == IDX_MAX);
    assign cur_val_s     = disp_digits_s[{idx_r, 2'b00} +: 4];

    // Slot timer: counts cycles within the current digit slot
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            slot_r <= {SLOT_W{1'b0}};
        end else if (slot_wrap_s) begin
            slot_r <= {SLOT_W{1'b0}};
        end else begin
            slot_r <= slot_r + SLOT_W'(1);
        end
    end

    // Digit index: steps from the leftmost digit down to digit 0, then back to the leftmost
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            idx_r <= IDX_MAX;
        end else if (slot_wrap_s) begin
            if (idx_r == {IDX_W{1'b0}}) begin
                idx_r <= IDX_MAX;
            end else begin
                idx_r <= idx_r - IDX_W'(1);
            end
        end
    end

    // Blink timer and phase, free running and independent of the scan
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (blink_cnt_r == BLINK_MAX) begin
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r   <= blink_cnt_r + BLINK_W'(1);
        end
    end

    // Holds the outputs dark for the first cycle after reset, before any snapshot exists
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            lit_en_r <= 1'b0;
        end else begin
            lit_en_r <= 1'b1;
        end
    end

    // Frame snapshot of the display inputs, taken at frame start
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            snap_digits_r   <= {(4*NUM_DIGITS){1'b0}};
            snap_dp_r       <= {NUM_DIGITS{1'b0}};
            snap_blank_lz_r <= 1'b0;
            snap_blink_r    <= {NUM_DIGITS{1'b0}};
        end else if (frame_start_s) begin
            snap_digits_r   <= digits;
            snap_dp_r       <= dp;
            snap_blank_lz_r <= blank_lz;
            snap_blink_r    <= blink;
        end
    end

    // Display source: at frame start the value being captured is used directly.
    // This makes the first cycle of a frame already show the new snapshot.
    always_comb begin
        disp_digits_s   = snap_digits_r;
        disp_dp_s       = snap_dp_r;
        disp_blank_lz_s = snap_blank_lz_r;
        disp_blink_s    = snap_blink_r;
        if (frame_start_s) begin
            disp_digits_s   = digits;
            disp_dp_s       = dp;
            disp_blank_lz_s = blank_lz;
            disp_blink_s    = blink;
        end else begin
            disp_digits_s   = snap_digits_r;
            disp_dp_s       = snap_dp_r;
            disp_blank_lz_s = snap_blank_lz_r;
            disp_blink_s    = snap_blink_r;
        end
    end

    // Leading-zero mask: digit i>0 is marked when it and every digit above it are zero
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lz_mask_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp_digits_s[4*i +: 4] == 4'h0);
            if (i != 0) begin
                lz_mask_s[i] = zero_run;
            end else begin
                lz_mask_s[i] = 1'b0;
            end
        end
    end

`ifdef SEG_BRIGHTNESS_EN
    localparam int THR_W = SLOT_W + 1;
    localparam int STEP  = REFRESH_COUNT / 16;

    logic [3:0]       snap_bright_r;
    logic [3:0]       disp_bright_s;
    logic [THR_W-1:0] thr_r;

    assign disp_bright_s = frame_start_s ? brightness : snap_bright_r;
    assign bright_on_s   = ({1'b0, slot_r} < thr_r);

    // Brightness snapshot, captured together with the other display inputs
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            snap_bright_r <= 4'h0;
        end else if (frame_start_s) begin
            snap_bright_r <= brightness;
        end
    end

    // Lit-time threshold as a registered constant multiply.
    // Slot 0 is always lit, so the one-cycle lag after a new snapshot cannot show through.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            thr_r <= {THR_W{1'b0}};
        end else begin
            thr_r <= THR_W'({1'b0, disp_bright_s} + 5'd1) * THR_W'(STEP);
        end
    end
`else
    assign bright_on_s = 1'b1;
`endif

    // Next output value. Priority order: blink-off, brightness-off, blank, decode.
    always_comb begin
        an_d_s   = AN_OFF;
        seg_d_s  = SEG_OFF;
        dp_n_d_s = 1'b1;
        if (!lit_en_r) begin
            an_d_s   = AN_OFF;
            seg_d_s  = SEG_OFF;
            dp_n_d_s = 1'b1;
        end else if (blink_phase_r && disp_blink_s[idx_r]) begin
            an_d_s   = AN_OFF;
            seg_d_s  = SEG_OFF;
            dp_n_d_s = 1'b1;
        end else if (!bright_on_s) begin
            an_d_s   = AN_OFF;
            seg_d_s  = SEG_OFF;
            dp_n_d_s = 1'b1;
        end else begin
            an_d_s   = ~(AN_ONE << idx_r);
            dp_n_d_s = ~disp_dp_s[idx_r];
            if (disp_blank_lz_s && lz_mask_s[idx_r]) begin
                seg_d_s = SEG_OFF;
            end else begin
                seg_d_s = decode_glyph(cur_val_s);
            end
        end
    end

    // Output register driving the pins
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            an   <= AN_OFF;
            seg  <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            an   <= an_d_s;
            seg  <= seg_d_s;
            dp_n <= dp_n_d_s;
        end
    end

endmodule

// File: tb/tb_seg_mux_n.sv
// Randomized scoreboard bench for seg_mux_n (4 digits, 16-cycle slots, 64-cycle blink).
// It runs one HEX_MODE=1 and one HEX_MODE=0 instance on the same stimulus.
module tb_seg_mux_n;

    localparam int N = 4;
    localparam int R = 16;
    localparam int B = 64;
    localparam logic [11:0] DARK = {4'b1111, 7'b1111111, 1'b1};

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [3:0]  blink;
`ifdef SEG_BRIGHTNESS_EN
    logic [3:0]  brightness;
    logic [3:0]  m_bright;
`endif
    logic [0:6]  seg_h1, seg_h0;
    logic        dp_n_h1, dp_n_h0;
    logic [3:0]  an_h1, an_h0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_c     = 0;
    logic [15:0] m_digits;
    logic [3:0]  m_dp;
    logic        m_blank_lz;
    logic [3:0]  m_blink;
    logic [23:0] exp_q[$];
    logic [23:0] mon_e;

    always #5 clk_100MHz = ~clk_100MHz;

    seg_mux_n #(.NUM_DIGITS(N), .REFRESH_COUNT(R), .BLINK_COUNT(B), .HEX_MODE(1)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .digits(digits), .dp(dp),
        .blank_lz(blank_lz), .blink(blink),
`ifdef SEG_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .seg(seg_h1), .dp_n(dp_n_h1), .an(an_h1)
    );

    seg_mux_n #(.NUM_DIGITS(N), .REFRESH_COUNT(R), .BLINK_COUNT(B), .HEX_MODE(0)) dut_h0 (
        .clk_100MHz(clk_100MHz), .reset(reset), .digits(digits), .dp(dp),
        .blank_lz(blank_lz), .blink(blink),
`ifdef SEG_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .seg(seg_h0), .dp_n(dp_n_h0), .an(an_h0)
    );

    function automatic logic [6:0] glyph_of(input logic [3:0] v, input bit hex);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b0000001;  4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;  4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;  4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;  4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;  4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;  4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;  4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;  4'hF: g = 7'b0111000;
            default: g = 7'b1111111;
        endcase
        if (!hex && v > 4'h9) g = 7'b1111111;
        return g;
    endfunction

    // Output after the edge that ends run-cycle c, from the frame snapshot (an, seg, dp_n)
    function automatic logic [11:0] model_out(input int c, input bit hex);
        int          slot, idx;
        logic [3:0]  an_e;
        logic [6:0]  g;
        logic [15:0] upper;
        slot = c % R;
        idx  = N - 1 - ((c / R) % N);
        if (c == 0) return DARK;
        if (((c / B) % 2) == 1 && m_blink[idx]) return DARK;
`ifdef SEG_BRIGHTNESS_EN
        if (slot >= (int'(m_bright) + 1) * (R / 16)) return DARK;
`endif
        an_e      = 4'b1111;
        an_e[idx] = 1'b0;
        upper     = m_digits >> (4 * idx);
        if (m_blank_lz && idx > 0 && upper == 16'h0000) g = 7'b1111111;
        else g = glyph_of(m_digits[4*idx +: 4], hex);
        return {an_e, g, ~m_dp[idx]};
    endfunction

    // Push the expected response for the coming edge, then move to the next negedge
    task automatic step();
        logic [23:0] e;
        if (reset) begin
            e   = {DARK, DARK};
            m_c = 0;
        end else begin
            if (m_c % (R * N) == 0) begin
                m_digits   = digits;
                m_dp       = dp;
                m_blank_lz = blank_lz;
                m_blink    = blink;
`ifdef SEG_BRIGHTNESS_EN
                m_bright   = brightness;
`endif
            end
            e   = {model_out(m_c, 1'b1), model_out(m_c, 1'b0)};
            m_c = m_c + 1;
        end
        exp_q.push_back(e);
        @(negedge clk_100MHz);
    endtask

    // Monitor: pops one expectation per edge and compares both instances
    always @(posedge clk_100MHz) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            n_tests = n_tests + 2;
            if ({an_h1, seg_h1, dp_n_h1} !== mon_e[23:12]) begin
                n_fail = n_fail + 1;
                $display("FAIL hex1_out t=%0t: got an=%b seg=%b dp_n=%b, want an=%b seg=%b dp_n=%b",
                         $time, an_h1, seg_h1, dp_n_h1, mon_e[23:20], mon_e[19:13], mon_e[12]);
            end
            if ({an_h0, seg_h0, dp_n_h0} !== mon_e[11:0]) begin
                n_fail = n_fail + 1;
                $display("FAIL hex0_out t=%0t: got an=%b seg=%b dp_n=%b, want an=%b seg=%b dp_n=%b",
                         $time, an_h0, seg_h0, dp_n_h0, mon_e[11:8], mon_e[7:1], mon_e[0]);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        digits   = 16'h0000;
        dp       = 4'b0000;
        blank_lz = 1'b0;
        blink    = 4'b0000;
`ifdef SEG_BRIGHTNESS_EN
        brightness = 4'hF;
`endif
        repeat (3) step();
        reset  = 1'b0;
        digits = 16'h1234;
        repeat (128) step();
        // leading-zero blanking
        digits = 16'h0070; blank_lz = 1'b1;
        repeat (64) step();
        digits = 16'h0000;
        repeat (64) step();
        blank_lz = 1'b0;
        repeat (64) step();
        // snapshot coherence: change in the middle of a frame
        while (m_c % (R * N) != 0) step();
        digits = 16'h1111;
        repeat (32) step();
        digits = 16'h2222;
        repeat (96) step();
        // hex decode and decimal point
        digits = 16'hABCD; dp = 4'b0100;
        repeat (64) step();
        // blink on digit 0
        dp = 4'b0000; digits = 16'h1234; blink = 4'b0001;
        repeat (192) step();
        blink = 4'b0000;
        // reset in the middle of a frame (slot 2, timer 7)
        while (m_c % (R * N) != 2 * R + 7) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (70) step();
`ifdef SEG_BRIGHTNESS_EN
        brightness = 4'd3;
        repeat (128) step();
`endif
        // randomized traffic
        repeat (1500) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       digits = 16'($urandom()) & 16'h000F;
                    1:       digits = 16'($urandom()) & 16'h00FF;
                    2:       digits = 16'($urandom()) & 16'h0FFF;
                    default: digits = 16'($urandom());
                endcase
            end
            if ($urandom_range(0, 15) == 0) dp = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0)
                blink = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
`ifdef SEG_BRIGHTNESS_EN
            if ($urandom_range(0, 31) == 0) brightness = 4'($urandom_range(0, 15));
`endif
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        step();
        @(negedge clk_100MHz);
        n_tests = n_tests + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
